// File: rtl/jtpang_busctl_pkg.sv
// Shared types and constants for the CPU-side object DMA bus responder.
package jtpang_busctl_pkg;

  localparam int unsigned MAXGRANT_DEF = 1024;
  localparam int unsigned CW_DEF       = 11;
  localparam int unsigned CPU_AW       = 12;
  localparam int unsigned DMA_AW       = 9;

  // Bus ownership phases of the DMA handshake
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_GRANT = 2'd2,
    ST_REL   = 2'd3
  } state_t;

endpackage

// File: rtl/jtpang_busctl_if.sv
// Z80-side bus, VRAM address port and DMA handshake signals of the responder.
interface jtpang_busctl_if;
  import jtpang_busctl_pkg::*;

  logic              cpu_cen;
  logic              cpu_cen_g;
  logic              mreq_n;
  logic              iorq_n;
  logic              wr_n;
  logic              dma_cs;
  logic [CPU_AW-1:0] cpu_addr;
  logic [DMA_AW-1:0] dma_addr;
  logic [CPU_AW-1:0] vram_addr;
  logic              dma_go;
  logic              busrq;
  logic              busak_n;
  logic              dma_busy;
  logic              wdog_err;

  // Responder side (the bus controller)
  modport slave (
    input  cpu_cen, mreq_n, iorq_n, wr_n, dma_cs, cpu_addr, dma_addr, busrq,
    output cpu_cen_g, vram_addr, dma_go, busak_n, dma_busy, wdog_err
  );

  // Environment side (CPU, decoder and object engine)
  modport master (
    output cpu_cen, mreq_n, iorq_n, wr_n, dma_cs, cpu_addr, dma_addr, busrq,
    input  cpu_cen_g, vram_addr, dma_go, busak_n, dma_busy, wdog_err
  );

endinterface

// File: rtl/jtpang_busctl_wdog.sv
// Grant-length watchdog: clearable up-counter with a terminal-count flag.
module jtpang_busctl_wdog
  import jtpang_busctl_pkg::*;
#(
  parameter int unsigned MAXGRANT = MAXGRANT_DEF,
  parameter int unsigned CW       = CW_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  // Last count of a grant; the grant lasts MAXGRANT cycles (counts 0..MAXGRANT-1)
  localparam logic [CW-1:0] LAST = CW'(MAXGRANT - 1);

  logic [CW-1:0] cnt;

  // Count grant cycles, holding at the terminal value
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && (cnt != LAST)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc_c = en && (cnt == LAST);

endmodule

// File: rtl/jtpang_busctl.sv
// CPU-side bus responder: DMA trigger, Z80 bus grant/release and VRAM address steering.
module jtpang_busctl
  import jtpang_busctl_pkg::*;
#(
  parameter int unsigned MAXGRANT = MAXGRANT_DEF,
  parameter int unsigned CW       = CW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  jtpang_busctl_if.slave  bus
);

  state_t state;
  state_t state_nxt;

  logic halt;
  logic halt_nxt;
  logic busak_n_r;
  logic busak_nxt;
  logic dma_go_r;
  logic go_nxt;
  logic busy_r;
  logic busy_nxt;
  logic wdog_r;
  logic wdog_nxt;
  logic wr_n_l;

  logic in_grant_c;
  logic trig_c;
  logic bus_idle_c;
  logic wdog_tc_c;

  assign in_grant_c = (state == ST_GRANT);

  // Write strobe ending on the trigger address; ignored unless the block is free
  assign trig_c = bus.wr_n & ~wr_n_l & ~bus.dma_cs & (state == ST_IDLE) & ~busy_r;

  // Z80 T-state boundary with no memory or I/O cycle in flight
  assign bus_idle_c = bus.cpu_cen & bus.mreq_n & bus.iorq_n;

  jtpang_busctl_wdog #(
    .MAXGRANT (MAXGRANT),
    .CW       (CW)
  ) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (~in_grant_c),
    .en    (in_grant_c),
    .tc_c  (wdog_tc_c)
  );

  // Next-state and registered-output decode
  always_comb begin
    state_nxt = state;
    go_nxt    = 1'b0;
    busy_nxt  = busy_r;
    wdog_nxt  = wdog_r;

    if (trig_c) begin
      go_nxt   = 1'b1;
      busy_nxt = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (bus.busrq) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (!bus.busrq)     state_nxt = ST_IDLE;
        else if (bus_idle_c) state_nxt = ST_GRANT;
      end
      ST_GRANT: begin
        // A normal request drop wins over a coincident watchdog expiry
        if (!bus.busrq) begin
          state_nxt = ST_REL;
        end else if (wdog_tc_c) begin
          state_nxt = ST_REL;
          wdog_nxt  = 1'b1;
        end
      end
      ST_REL: begin
        // Stay released (CPU still frozen) until the engine withdraws its request
        if (!bus.busrq) begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    busak_nxt = (state_nxt != ST_GRANT);
    halt_nxt  = (state_nxt == ST_GRANT) || (state_nxt == ST_REL);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      halt      <= 1'b0;
      busak_n_r <= 1'b1;
      dma_go_r  <= 1'b0;
      busy_r    <= 1'b0;
      wdog_r    <= 1'b0;
      wr_n_l    <= 1'b1;
    end else begin
      state     <= state_nxt;
      halt      <= halt_nxt;
      busak_n_r <= busak_nxt;
      dma_go_r  <= go_nxt;
      busy_r    <= busy_nxt;
      wdog_r    <= wdog_nxt;
      wr_n_l    <= bus.wr_n;
    end
  end

  assign bus.busak_n   = busak_n_r;
  assign bus.dma_go    = dma_go_r;
  assign bus.dma_busy  = busy_r;
  assign bus.wdog_err  = wdog_r;
  assign bus.cpu_cen_g = bus.cpu_cen & ~halt;
  assign bus.vram_addr = busak_n_r ? bus.cpu_addr : CPU_AW'(bus.dma_addr);

endmodule

// File: tb/tb_jtpang_busctl.sv
// Randomized self-checking bench for jtpang_busctl with a scenario-level reference.
module tb_jtpang_busctl;
  import jtpang_busctl_pkg::*;

  localparam int unsigned MG  = 16;
  localparam int unsigned CWT = 5;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  jtpang_busctl_if bus();

  jtpang_busctl #(
    .MAXGRANT (MG),
    .CW       (CWT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Expected registered behaviour after the coming clock edge
  logic exp_busak_n;
  logic exp_halt;
  logic exp_go;
  logic exp_busy;
  logic exp_wdog;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock and compare every output against the reference
  task automatic tick(input string tag);
    logic [CPU_AW-1:0] exp_vram;
    @(posedge clk);
    #1;
    exp_vram = exp_busak_n ? bus.cpu_addr : CPU_AW'(bus.dma_addr);
    check({tag, "/busak_n"},   32'(bus.busak_n),   32'(exp_busak_n));
    check({tag, "/dma_go"},    32'(bus.dma_go),    32'(exp_go));
    check({tag, "/dma_busy"},  32'(bus.dma_busy),  32'(exp_busy));
    check({tag, "/wdog_err"},  32'(bus.wdog_err),  32'(exp_wdog));
    check({tag, "/vram_addr"}, 32'(bus.vram_addr), 32'(exp_vram));
    check({tag, "/cpu_cen_g"}, 32'(bus.cpu_cen_g), 32'(bus.cpu_cen & ~exp_halt));
    exp_go = 1'b0;
  endtask

  task automatic drive_bg();
    bus.cpu_cen  = 1'($urandom_range(0, 1));
    bus.cpu_addr = 12'($urandom);
    bus.dma_addr = 9'($urandom);
  endtask

  // One DMA transaction: optional trigger, request, grant after the Z80 bus
  // goes idle, hold for 'hold' cycles, then release (normal, forced or reset)
  task automatic run_txn(input bit do_trig, input bit with_req, input int mem_strobes,
                         input bit use_io, input int hold, input int rst_at);
    int left;
    int l_edge;
    int r_edge;
    int i_edge;
    bit qual;
    bit granted;

    bus.busrq  = 1'b0;
    bus.wr_n   = 1'b1;
    bus.dma_cs = 1'b1;
    bus.iorq_n = 1'b1;
    repeat ($urandom_range(1, 3)) begin
      drive_bg();
      bus.mreq_n = 1'($urandom_range(0, 1));
      tick("idle");
    end
    bus.mreq_n = 1'b1;

    if (do_trig) begin
      drive_bg(); bus.dma_cs = 1'b0; bus.wr_n = 1'b0;
      tick("wr_low");
      drive_bg(); bus.wr_n = 1'b1; bus.busrq = with_req;
      exp_go = 1'b1; exp_busy = 1'b1;
      tick("trig");
      bus.dma_cs = 1'b1;
      if (!with_req) begin
        drive_bg(); bus.dma_cs = 1'b0; bus.wr_n = 1'b0;
        tick("wr2_low");
        drive_bg(); bus.wr_n = 1'b1;
        tick("wr2_busy");
        bus.dma_cs = 1'b1;
      end
    end

    if (!bus.busrq) begin
      drive_bg(); bus.busrq = 1'b1;
      tick("req");
    end

    // Grant on the first bus-idle cpu_cen after the request was seen
    left    = mem_strobes;
    granted = 1'b0;
    for (int k = 1; k <= 200 && !granted; k++) begin
      drive_bg();
      if (k > 60) bus.cpu_cen = 1'b1;
      bus.mreq_n = (left > 0 && !use_io) ? 1'b0 : 1'b1;
      bus.iorq_n = (left > 0 && use_io)  ? 1'b0 : 1'b1;
      bus.wr_n   = 1'($urandom_range(0, 1));
      bus.dma_cs = 1'($urandom_range(0, 1));
      qual = bus.cpu_cen && bus.mreq_n && bus.iorq_n;
      if (bus.cpu_cen && left > 0) left--;
      if (qual) begin
        exp_busak_n = 1'b0;
        exp_halt    = 1'b1;
        granted     = 1'b1;
      end
      tick("wait");
    end
    bus.mreq_n = 1'b1;
    bus.iorq_n = 1'b1;

    // l: first edge with busrq low; r: release edge; i: edge back to idle
    l_edge = hold + 1;
    r_edge = (l_edge < int'(MG)) ? l_edge : int'(MG);
    i_edge = (r_edge + 1 > l_edge) ? r_edge + 1 : l_edge;
    for (int n = 1; n <= i_edge; n++) begin
      drive_bg();
      bus.busrq  = (n <= hold);
      bus.wr_n   = (n == i_edge) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.dma_cs = 1'($urandom_range(0, 1));
      if (n == rst_at && n < r_edge) begin
        rst_n = 1'b0;
        exp_busak_n = 1'b1; exp_halt = 1'b0; exp_busy = 1'b0; exp_wdog = 1'b0;
        tick("rst_grant");
        rst_n = 1'b1; bus.busrq = 1'b0; bus.wr_n = 1'b1; drive_bg();
        tick("rst_after");
        bus.dma_cs = 1'b1;
        return;
      end
      if (n == r_edge) begin
        exp_busak_n = 1'b1;
        if (hold >= int'(MG)) exp_wdog = 1'b1;
      end
      if (n == i_edge) begin
        exp_halt = 1'b0;
        exp_busy = 1'b0;
      end
      tick((n < r_edge) ? "grant" : ((n < i_edge) ? "rel" : "back_idle"));
    end
    bus.dma_cs = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.busrq  = 1'b1;
    bus.wr_n   = 1'b1;
    bus.dma_cs = 1'b1;
    bus.mreq_n = 1'b1;
    bus.iorq_n = 1'b1;
    drive_bg();
    exp_busak_n = 1'b1;
    exp_halt    = 1'b0;
    exp_go      = 1'b0;
    exp_busy    = 1'b0;
    exp_wdog    = 1'b0;

    repeat (4) begin
      drive_bg();
      tick("reset");
    end
    rst_n = 1'b1; bus.busrq = 1'b0;
    tick("post_reset");

    run_txn(1'b1, 1'b0, 3, 1'b0, 4, 0);        // memory cycle holds off grant
    run_txn(1'b1, 1'b1, 0, 1'b0, MG - 1, 0);   // busrq drop coincides with expiry
    run_txn(1'b0, 1'b0, 2, 1'b1, MG + 3, 0);   // forced release, REL waits for busrq low
    run_txn(1'b0, 1'b0, 0, 1'b0, 0, 0);        // shortest grant
    run_txn(1'b1, 1'b0, 2, 1'b0, 20, 5);       // reset mid-grant clears wdog_err

    for (int t = 0; t < 40; t++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, MG + 6)),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 10)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
